vec_cmd_issuer: RTL and testbench

- Synthesizable initiator for the vector accelerator's command interface. It performs the role that the bench plays today.
- Accepts one command at a time from a host-side valid/ready port, decodes it, and drives the accelerator's op/addr/data inputs with a valid/ready handshake.
- Waits for the accelerator's done_o, collects read data through v/yumi, and returns it on a host response port.
- Sits between the host or control fabric and the accelerator top.

---
 rtl/vec_cmd_issuer.sv | 179 +++++++++++++++++
 tb/tb_vec_cmd_issuer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_cmd_issuer.sv
// Command issuer for the vector accelerator: takes one host command, drives the accelerator
// handshake, waits for done, and returns read data. Define VEC_CMD_ISSUER_PERF_EN for perf_cycles_o.
module vec_cmd_issuer #(
  parameter int els_p  = 12,
  parameter int vlen_p = 2,
  parameter int vdw_p  = 4,
  localparam int aw_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int dw_lp = vlen_p * vdw_p
) (
  input  logic             clk_i,
  input  logic             reset_n_i,

  input  logic             cmd_v_i,
  output logic             cmd_ready_o,
  input  logic [3:0]       cmd_op_i,
  input  logic [aw_lp-1:0] cmd_addrA_i,
  input  logic [aw_lp-1:0] cmd_addrB_i,
  input  logic [aw_lp-1:0] cmd_addrD_i,
  input  logic [vdw_p-1:0] cmd_scalar_i,
  input  logic [dw_lp-1:0] cmd_wdata_i,
  output logic             cmd_done_o,
  output logic             err_o,

  output logic             resp_v_o,
  output logic [dw_lp-1:0] resp_data_o,
  input  logic             resp_yumi_i,

  output logic [3:0]       acc_op_o,
  output logic [aw_lp-1:0] acc_addrA_o,
  output logic [aw_lp-1:0] acc_addrB_o,
  output logic [aw_lp-1:0] acc_addrD_o,
  output logic [vdw_p-1:0] acc_scalar_o,
  output logic [dw_lp-1:0] acc_wdata_o,
  output logic             acc_v_o,
  input  logic             acc_ready_i,
  input  logic             acc_done_i,
  input  logic [dw_lp-1:0] acc_r_data_i,
  input  logic             acc_v_i,
  output logic             acc_yumi_o
`ifdef VEC_CMD_ISSUER_PERF_EN
  ,
  output logic [15:0]      perf_cycles_o
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [3:0] OP_READ = 4'b1000;

  state_e             state_r, state_n;
  logic [3:0]         op_r;
  logic [aw_lp-1:0]   addr_a_r, addr_b_r, addr_d_r;
  logic [vdw_p-1:0]   scalar_r;
  logic [dw_lp-1:0]   wdata_r;
  logic [dw_lp-1:0]   resp_data_r;
  logic               err_r;
  logic               done_r;

  logic               op_legal;
  logic               is_read;
  logic               yumi;
  logic               latch_cmd;
  logic               set_err;
  logic               done_n;
  logic               capture_resp;

  // ALU groups 00xx/01xx exclude their xx=11 code; the 1xxx group only has read, write, mmul.
  always_comb begin
    op_legal = 1'b0;
    if (!cmd_op_i[3])
      op_legal = (cmd_op_i[1:0] != 2'b11);
    else
      op_legal = (cmd_op_i == 4'b1000) || (cmd_op_i == 4'b1001) || (cmd_op_i == 4'b1111);
  end

  assign is_read = (op_r == OP_READ);
  assign yumi    = (state_r == WAIT) && is_read && acc_v_i && acc_done_i;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_n      = state_r;
    latch_cmd    = 1'b0;
    set_err      = 1'b0;
    done_n       = 1'b0;
    capture_resp = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_v_i) begin
          latch_cmd = 1'b1;
          if (op_legal) begin
            state_n = ISSUE;
          end else begin
            set_err = 1'b1;
            done_n  = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (acc_ready_i) state_n = WAIT;
      end
      WAIT: begin
        if (is_read) begin
          if (yumi) begin
            capture_resp = 1'b1;
            state_n      = RESP;
          end
        end else if (acc_done_i) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      RESP: begin
        if (resp_yumi_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments with an asynchronous active-low clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      op_r        <= '0;
      addr_a_r    <= '0;
      addr_b_r    <= '0;
      addr_d_r    <= '0;
      scalar_r    <= '0;
      wdata_r     <= '0;
      resp_data_r <= '0;
      err_r       <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_n;
      done_r  <= done_n;
      if (set_err) err_r <= 1'b1;
      if (latch_cmd) begin
        op_r     <= cmd_op_i;
        addr_a_r <= cmd_addrA_i;
        addr_b_r <= cmd_addrB_i;
        addr_d_r <= cmd_addrD_i;
        scalar_r <= cmd_scalar_i;
        wdata_r  <= cmd_wdata_i;
      end
      if (capture_resp) resp_data_r <= acc_r_data_i;
    end
  end

`ifdef VEC_CMD_ISSUER_PERF_EN
  logic [15:0] perf_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      perf_r <= '0;
    end else if ((state_r == IDLE) && cmd_v_i && op_legal) begin
      perf_r <= '0;
    end else if (((state_r == ISSUE) || (state_r == WAIT)) && (perf_r != 16'hFFFF)) begin
      perf_r <= perf_r + 16'd1;
    end
  end

  assign perf_cycles_o = perf_r;
`endif

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign cmd_ready_o  = (state_r == IDLE) && reset_n_i;
  assign cmd_done_o   = done_r;
  assign err_o        = err_r;
  assign resp_v_o     = (state_r == RESP);
  assign resp_data_o  = resp_data_r;
  assign acc_v_o      = (state_r == ISSUE);
  assign acc_yumi_o   = yumi;
  assign acc_op_o     = op_r;
  assign acc_addrA_o  = addr_a_r;
  assign acc_addrB_o  = addr_b_r;
  assign acc_addrD_o  = addr_d_r;
  assign acc_scalar_o = scalar_r;
  assign acc_wdata_o  = wdata_r;

endmodule

// File: tb/tb_vec_cmd_issuer.sv
// Self-checking bench for vec_cmd_issuer: the bench plays host and a small accelerator model,
// with scoreboard queues for expected accelerator commands and read responses.
module tb_vec_cmd_issuer;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SW = 4;

  typedef struct packed {
    logic [3:0]    op;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] d;
    logic [SW-1:0] scalar;
    logic [DW-1:0] wdata;
  } acc_cmd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_v;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_a, cmd_b, cmd_d;
  logic [SW-1:0] cmd_scalar;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_done;
  logic          err;
  logic          resp_v;
  logic [DW-1:0] resp_data;
  logic          resp_yumi;
  logic [3:0]    acc_op;
  logic [AW-1:0] acc_a, acc_b, acc_d;
  logic [SW-1:0] acc_scalar;
  logic [DW-1:0] acc_wdata;
  logic          acc_v_out;
  logic          acc_ready;
  logic          acc_done;
  logic [DW-1:0] acc_rdata;
  logic          acc_v_in;
  logic          acc_yumi;
`ifdef VEC_CMD_ISSUER_PERF_EN
  logic [15:0]   perf_cycles;
`endif

  acc_cmd_t      acc_q[$];
  logic [DW-1:0] resp_q[$];
  logic [DW-1:0] mem [16];
  int            n_vec  = 0;
  int            n_miss = 0;

  vec_cmd_issuer #(.els_p(12), .vlen_p(2), .vdw_p(4)) dut (
    .clk_i        (clk),
    .reset_n_i    (rst_n),
    .cmd_v_i      (cmd_v),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_addrA_i  (cmd_a),
    .cmd_addrB_i  (cmd_b),
    .cmd_addrD_i  (cmd_d),
    .cmd_scalar_i (cmd_scalar),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_done_o   (cmd_done),
    .err_o        (err),
    .resp_v_o     (resp_v),
    .resp_data_o  (resp_data),
    .resp_yumi_i  (resp_yumi),
    .acc_op_o     (acc_op),
    .acc_addrA_o  (acc_a),
    .acc_addrB_o  (acc_b),
    .acc_addrD_o  (acc_d),
    .acc_scalar_o (acc_scalar),
    .acc_wdata_o  (acc_wdata),
    .acc_v_o      (acc_v_out),
    .acc_ready_i  (acc_ready),
    .acc_done_i   (acc_done),
    .acc_r_data_i (acc_rdata),
    .acc_v_i      (acc_v_in),
    .acc_yumi_o   (acc_yumi)
`ifdef VEC_CMD_ISSUER_PERF_EN
    ,
    .perf_cycles_o(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit legal_op(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd15: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Accelerator model: write stores, mmul computes row D = A[0]*mem[B] + A[1]*mem[B+1] per element.
  // ALU results are never read back, so they do not update the model.
  task automatic apply_model(input acc_cmd_t h);
    logic [DW-1:0] av, b0, b1, r;
    if (h.op == 4'b1001) begin
      mem[h.d] = h.wdata;
    end else if (h.op == 4'b1111) begin
      av = mem[h.a];
      b0 = mem[h.b];
      b1 = mem[h.b + 4'd1];
      for (int j = 0; j < 2; j++)
        r[j*4 +: 4] = av[3:0] * b0[j*4 +: 4] + av[7:4] * b1[j*4 +: 4];
      mem[h.d] = r;
    end
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d, input logic [SW-1:0] scalar,
                         input logic [DW-1:0] wdata, input int ready_dly, input int done_dly,
                         input logic [DW-1:0] exp_rd);
    acc_cmd_t exp_c, h;
    bit       is_rd;
    is_rd = (op == 4'b1000);
    @(negedge clk);
    cmd_v = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_d = d;
    cmd_scalar = scalar; cmd_wdata = wdata;
    if (legal_op(op)) acc_q.push_back('{op, a, b, d, scalar, wdata});
    if (is_rd) resp_q.push_back(exp_rd);
    check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_v = 1'b0;
    if (!legal_op(op)) begin
      check("illegal_done", cmd_done, 1);
      check("illegal_no_issue", acc_v_out, 0);
      check("illegal_err", err, 1);
      @(negedge clk);
      check("illegal_done_drop", cmd_done, 0);
      check("illegal_no_issue2", acc_v_out, 0);
      return;
    end
    exp_c = acc_q.pop_front();
    h = '0;
    for (int i = 0; i <= ready_dly; i++) begin
      check("acc_v_issue", acc_v_out, 1);
      check("acc_fields", {acc_op, acc_a, acc_b, acc_d, acc_scalar, acc_wdata}, exp_c);
      acc_ready = (i == ready_dly);
      h = '{acc_op, acc_a, acc_b, acc_d, acc_scalar, acc_wdata};
      @(negedge clk);
    end
    acc_ready = 1'b0;
    for (int i = 0; i <= done_dly; i++) begin
      check("acc_v_wait", acc_v_out, 0);
      check("no_early_done", cmd_done, 0);
      if (i == done_dly) begin
        acc_done = 1'b1;
        if (is_rd) begin
          acc_v_in  = 1'b1;
          acc_rdata = mem[h.a];
        end
        #1;
        check("acc_yumi", acc_yumi, is_rd);
      end
      @(negedge clk);
    end
    acc_done = 1'b0;
    acc_v_in = 1'b0;
    if (!is_rd) begin
      check("cmd_done_pulse", cmd_done, 1);
      check("cmd_ready_after", cmd_ready, 1);
      apply_model(h);
      @(negedge clk);
      check("cmd_done_one", cmd_done, 0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        check("resp_v", resp_v, 1);
        check("resp_data", resp_data, resp_q[0]);
        check("read_no_done", cmd_done, 0);
        check("resp_not_ready", cmd_ready, 0);
        if (k == 2) resp_yumi = 1'b1;
        @(negedge clk);
      end
      resp_yumi = 1'b0;
      void'(resp_q.pop_front());
      check("resp_v_drop", resp_v, 0);
      check("ready_after_resp", cmd_ready, 1);
      check("read_no_done2", cmd_done, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_v = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_d = '0;
    cmd_scalar = '0; cmd_wdata = '0; resp_yumi = 1'b0;
    acc_ready = 1'b0; acc_done = 1'b0; acc_rdata = '0; acc_v_in = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    #3;
    check("rst_ready", cmd_ready, 0);
    check("rst_acc_v", acc_v_out, 0);
    check("rst_resp_v", resp_v, 0);
    check("rst_done", cmd_done, 0);
    check("rst_err", err, 0);
    check("rst_fields", {acc_op, acc_a, acc_b, acc_d, acc_scalar, acc_wdata}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_post_rst", cmd_ready, 1);

    // Write, ready immediately, done two cycles after the handshake
    run_cmd(4'b1001, 4'd0, 4'd0, 4'd3, 4'd0, 8'b0011_0010, 0, 2, 8'h00);
    check("err_clear_write", err, 0);

    // Read back a freshly written vector
    run_cmd(4'b1001, 4'd0, 4'd0, 4'd0, 4'd0, 8'b0001_0001, 0, 0, 8'h00);
    run_cmd(4'b1000, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1, 1, 8'b0001_0001);

    // mmul under five cycles of accelerator backpressure, then read the result
    run_cmd(4'b1001, 4'd0, 4'd0, 4'd2, 4'd0, 8'h25, 0, 0, 8'h00);
    run_cmd(4'b1001, 4'd0, 4'd0, 4'd3, 4'd0, 8'h23, 0, 0, 8'h00);
    run_cmd(4'b1111, 4'd0, 4'd2, 4'd4, 4'd0, 8'h00, 5, 2, 8'h00);
    run_cmd(4'b1000, 4'd4, 4'd0, 4'd0, 4'd0, 8'h00, 0, 0, 8'b0100_1000);

    // ALU ops pass scalar and addresses through untouched
    run_cmd(4'b0101, 4'd1, 4'd2, 4'd5, 4'hA, 8'hC3, 1, 0, 8'h00);
    run_cmd(4'b0010, 4'd11, 4'd7, 4'd9, 4'h5, 8'h3C, 0, 1, 8'h00);

    // Illegal ops set the sticky error; a later write still completes
    run_cmd(4'b1011, 4'd1, 4'd1, 4'd1, 4'd0, 8'hFF, 0, 0, 8'h00);
    run_cmd(4'b1001, 4'd0, 4'd0, 4'd6, 4'd0, 8'h5A, 0, 0, 8'h00);
    check("err_sticky", err, 1);
    run_cmd(4'b0011, 4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 0, 0, 8'h00);
    run_cmd(4'b1000, 4'd6, 4'd0, 4'd0, 4'd0, 8'h00, 0, 0, 8'h5A);
    check("err_sticky2", err, 1);

`ifdef VEC_CMD_ISSUER_PERF_EN
    run_cmd(4'b1001, 4'd0, 4'd0, 4'd7, 4'd0, 8'h77, 2, 2, 8'h00);
    check("perf_cycles", perf_cycles, 16'd6);
    @(negedge clk);
    check("perf_hold", perf_cycles, 16'd6);
`endif

    // Asynchronous reset while a read waits for data
    @(negedge clk);
    cmd_v = 1'b1; cmd_op = 4'b1000; cmd_a = 4'd3;
    @(negedge clk);
    cmd_v = 1'b0;
    check("rst_test_issue", acc_v_out, 1);
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    check("rst_test_wait", acc_v_out, 0);
    acc_v_in = 1'b1; acc_done = 1'b1; acc_rdata = 8'h99;
    #1;
    check("rst_test_yumi_pre", acc_yumi, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_acc_v", acc_v_out, 0);
    check("rst_mid_yumi", acc_yumi, 0);
    check("rst_mid_resp_v", resp_v, 0);
    check("rst_mid_done", cmd_done, 0);
    check("rst_mid_err", err, 0);
    acc_v_in = 1'b0; acc_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_ready", cmd_ready, 1);
      check("post_rst_no_done", cmd_done, 0);
      check("post_rst_resp_v", resp_v, 0);
    end

    check("scoreboard_empty", acc_q.size() + resp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
